// File: rtl/xrotate_nco.sv
// xrotate_nco: complex rotator by e^(j*theta), direct phase or internal NCO.
// Seven-stage pipeline around an external synchronous octant sin/cos ROM.
module xrotate_nco #(
  parameter int DATA_WIDTH         = 16,
  parameter int PHASE_WIDTH        = 16,
  parameter int ROTATE_LEN_SHIFT   = 9,
  parameter int ROTATE_SCALE_SHIFT = 11,
  parameter int PI                 = 1608
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          mode,
  input  logic                          phase_reset,
  input  logic signed [DATA_WIDTH-1:0]  in_i,
  input  logic signed [DATA_WIDTH-1:0]  in_q,
  input  logic signed [PHASE_WIDTH-1:0] phase,
  input  logic signed [PHASE_WIDTH-1:0] phase_inc,
  input  logic                          input_valid,
  output logic [ROTATE_LEN_SHIFT-1:0]   rot_addr,
  input  logic [31:0]                   rot_data,
  output logic signed [DATA_WIDTH-1:0]  out_i,
  output logic signed [DATA_WIDTH-1:0]  out_q,
  output logic                          output_valid,
  output logic                          phase_err,
  output logic                          sat_err
);
  localparam int DW  = DATA_WIDTH;
  localparam int PW  = PHASE_WIDTH;
  localparam int RL  = ROTATE_LEN_SHIFT;
  localparam int SC  = ROTATE_SCALE_SHIFT;
  localparam int RTW = 17;
  localparam int PRW = DW + RTW + 1;

  localparam logic signed [PW:0] PI_X  = (PW+1)'(PI);
  localparam logic signed [PW:0] PI2_X = (PW+1)'(2 * PI);
  localparam logic [PW-1:0] PI_U   = PW'(PI);
  localparam logic [PW-1:0] PI_4   = PW'(PI >> 2);
  localparam logic [PW-1:0] PI_2   = PW'(PI >> 1);
  localparam logic [PW-1:0] PI_3_4 = PW'((PI >> 1) + (PI >> 2));
  localparam logic signed [PRW-1:0] RND  = PRW'(2 ** (SC - 1));
  localparam logic signed [PRW-1:0] MAXV = PRW'(2 ** (DW - 1) - 1);
  localparam logic signed [PRW-1:0] MINV = ~MAXV;

  typedef struct packed {
    logic signed [PW-1:0]  acc;
    logic                  perr;
    logic                  serr;
    logic                  v0;
    logic signed [DW-1:0]  i0;
    logic signed [DW-1:0]  q0;
    logic signed [PW-1:0]  th0;
    logic                  v1;
    logic signed [DW-1:0]  i1;
    logic signed [DW-1:0]  q1;
    logic [PW-1:0]         a1;
    logic                  n1;
    logic                  v2;
    logic signed [DW-1:0]  i2;
    logic signed [DW-1:0]  q2;
    logic [1:0]            o2;
    logic                  n2;
    logic [RL-1:0]         addr;
    logic                  v3;
    logic signed [DW-1:0]  i3;
    logic signed [DW-1:0]  q3;
    logic [1:0]            o3;
    logic                  n3;
    logic                  v4;
    logic signed [DW-1:0]  i4;
    logic signed [DW-1:0]  q4;
    logic signed [RTW-1:0] ri4;
    logic signed [RTW-1:0] rq4;
    logic                  v5;
    logic signed [PRW-1:0] pi5;
    logic signed [PRW-1:0] pq5;
    logic                  v6;
    logic signed [DW-1:0]  oi6;
    logic signed [DW-1:0]  oq6;
  } st_t;

  st_t st_q, st_d;

  logic signed [PW:0]    ph_x;
  logic signed [PW:0]    nxt_x;
  logic signed [PW-1:0]  th;
  logic signed [RTW-1:0] cs;
  logic signed [RTW-1:0] sn;
  logic signed [RTW-1:0] ri;
  logic signed [RTW-1:0] rq;
  logic signed [PRW-1:0] p_i;
  logic signed [PRW-1:0] p_q;
  logic [DW:0]           si;
  logic [DW:0]           sq;

  function automatic logic signed [PW:0] wrap(input logic signed [PW:0] v);
    if (v > PI_X) return v - PI2_X;
    if (v < -PI_X) return v + PI2_X;
    return v;
  endfunction

  // round half up, then clip; top bit flags a clip
  function automatic logic [DW:0] sat(input logic signed [PRW-1:0] p);
    logic signed [PRW-1:0] r;
    r = (p + RND) >>> SC;
    if (r > MAXV) return {1'b1, DW'(MAXV)};
    if (r < MINV) return {1'b1, DW'(MINV)};
    return {1'b0, DW'(r)};
  endfunction

  // next state of every stage; enable low holds everything
  always_comb begin
    st_d  = st_q;
    ph_x  = (PW+1)'(phase);
    nxt_x = (PW+1)'($signed(st_q.acc)) + (PW+1)'(phase_inc);
    th    = $signed(st_q.th0);
    cs    = RTW'($signed(rot_data[31:16]));
    sn    = RTW'($signed(rot_data[15:0]));
    case (st_q.o3)
      2'd0:    begin ri = cs;  rq = sn; end
      2'd1:    begin ri = sn;  rq = cs; end
      2'd2:    begin ri = -sn; rq = cs; end
      default: begin ri = -cs; rq = sn; end
    endcase
    if (st_q.n3) rq = -rq;
    p_i = PRW'($signed(st_q.i4)) * PRW'($signed(st_q.ri4))
        - PRW'($signed(st_q.q4)) * PRW'($signed(st_q.rq4));
    p_q = PRW'($signed(st_q.i4)) * PRW'($signed(st_q.rq4))
        + PRW'($signed(st_q.q4)) * PRW'($signed(st_q.ri4));
    si = sat($signed(st_q.pi5));
    sq = sat($signed(st_q.pq5));
    if (enable) begin
      st_d.v0 = input_valid;
      st_d.i0 = in_i;
      st_d.q0 = in_q;
      if (mode) st_d.th0 = phase_reset ? '0 : st_q.acc;
      else st_d.th0 = PW'(wrap(ph_x));
      if (mode && phase_reset) st_d.acc = '0;
      else if (mode && input_valid) st_d.acc = PW'(wrap(nxt_x));
      if (!mode && input_valid && (ph_x > PI2_X || ph_x < -PI2_X))
        st_d.perr = 1'b1;
      st_d.v1 = st_q.v0;
      st_d.i1 = st_q.i0;
      st_d.q1 = st_q.q0;
      st_d.n1 = th[PW-1];
      st_d.a1 = th[PW-1] ? PW'(-th) : PW'(th);
      st_d.v2 = st_q.v1;
      st_d.i2 = st_q.i1;
      st_d.q2 = st_q.q1;
      st_d.n2 = st_q.n1;
      if (st_q.a1 <= PI_4) begin
        st_d.o2   = 2'd0;
        st_d.addr = RL'(st_q.a1);
      end else if (st_q.a1 <= PI_2) begin
        st_d.o2   = 2'd1;
        st_d.addr = RL'(PI_2 - st_q.a1);
      end else if (st_q.a1 <= PI_3_4) begin
        st_d.o2   = 2'd2;
        st_d.addr = RL'(st_q.a1 - PI_2);
      end else begin
        st_d.o2   = 2'd3;
        st_d.addr = RL'(PI_U - st_q.a1);
      end
      st_d.v3  = st_q.v2;
      st_d.i3  = st_q.i2;
      st_d.q3  = st_q.q2;
      st_d.o3  = st_q.o2;
      st_d.n3  = st_q.n2;
      st_d.v4  = st_q.v3;
      st_d.i4  = st_q.i3;
      st_d.q4  = st_q.q3;
      st_d.ri4 = ri;
      st_d.rq4 = rq;
      st_d.v5  = st_q.v4;
      st_d.pi5 = p_i;
      st_d.pq5 = p_q;
      st_d.v6  = st_q.v5;
      st_d.oi6 = DW'(si);
      st_d.oq6 = DW'(sq);
      if (st_q.v5 && (si[DW] || sq[DW])) st_d.serr = 1'b1;
    end
  end

  // pipeline registers; reset wins over enable
  always_ff @(posedge clock) begin
    if (reset) st_q <= '0;
    else st_q <= st_d;
  end

  assign rot_addr     = st_q.addr;
  assign out_i        = st_q.oi6;
  assign out_q        = st_q.oq6;
  assign output_valid = st_q.v6;
  assign phase_err    = st_q.perr;
  assign sat_err      = st_q.serr;
endmodule

// File: tb/tb_xrotate_nco.sv
// tb_xrotate_nco: directed scoreboard bench for xrotate_nco.
// Ideal octant ROM; expected samples follow from exact quarter-turn rotations.
module tb_xrotate_nco;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic mode = 1'b0;
  logic phase_reset = 1'b0;
  logic input_valid = 1'b0;
  logic signed [15:0] in_i = '0;
  logic signed [15:0] in_q = '0;
  logic signed [15:0] phase = '0;
  logic signed [15:0] phase_inc = '0;
  logic [8:0] rot_addr;
  logic [31:0] rot_data = '0;
  logic signed [15:0] out_i;
  logic signed [15:0] out_q;
  logic output_valid;
  logic phase_err;
  logic sat_err;

  typedef struct {
    int ei;
    int eq;
    int due;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int ecnt = 0;
  int acc_m = 0;
  logic en_last = 1'b0;
  int inc_tab[4] = '{0, 804, -804, 1608};

  always #5 clk = ~clk;

  xrotate_nco dut (
    .clock(clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .phase_reset(phase_reset),
    .in_i(in_i),
    .in_q(in_q),
    .phase(phase),
    .phase_inc(phase_inc),
    .input_valid(input_valid),
    .rot_addr(rot_addr),
    .rot_data(rot_data),
    .out_i(out_i),
    .out_q(out_q),
    .output_valid(output_valid),
    .phase_err(phase_err),
    .sat_err(sat_err)
  );

  function automatic logic [31:0] rom_f(input logic [8:0] a);
    real ang;
    int c;
    int s;
    logic [15:0] c16;
    logic [15:0] s16;
    ang = real'(a) * 3.14159265358979 / 1608.0;
    c = $rtoi(2048.0 * $cos(ang) + 0.5);
    s = $rtoi(2048.0 * $sin(ang) + 0.5);
    c16 = c[15:0];
    s16 = s[15:0];
    return {c16, s16};
  endfunction

  // synchronous ROM that holds while the pipeline is stalled
  always @(posedge clk) if (enable) rot_data <= rom_f(rot_addr);

  task automatic check(input string tag, input int act, input int exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // enabled-edge counter
  initial forever begin
    @(posedge clk);
    en_last = enable;
    if (enable) ecnt++;
  end

  // output monitor: pops the scoreboard once per enabled edge
  initial forever begin
    @(negedge clk);
    if (en_last && output_valid) begin
      check("unexpected_output", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_i", int'(out_i), e.ei);
        check("out_q", int'(out_q), e.eq);
        check("latency", ecnt, e.due);
      end
    end
  end

  task automatic send(input int di, input int dq, input int ph,
                      input int inc, input logic prst,
                      input int ei, input int eq);
    enable = 1'b1;
    input_valid = 1'b1;
    in_i = 16'(di);
    in_q = 16'(dq);
    phase = 16'(ph);
    phase_inc = 16'(inc);
    phase_reset = prst;
    sb.push_back('{ei, eq, ecnt + 7});
    @(negedge clk);
    input_valid = 1'b0;
    phase_reset = 1'b0;
  endtask

  task automatic idle(input int n);
    enable = 1'b1;
    input_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic stall(input int n);
    enable = 1'b0;
    input_valid = 1'b1;
    in_i = 16'sh1234;
    phase_inc = 16'sd804;
    phase_reset = 1'b1;
    repeat (n) @(negedge clk);
    enable = 1'b1;
    input_valid = 1'b0;
    phase_reset = 1'b0;
  endtask

  task automatic nco_send(input int di, input int dq, input int inc,
                          input logic prst);
    int th;
    int k;
    int ei;
    int eq;
    int s;
    th = prst ? 0 : acc_m;
    k = ((th / 804) % 4 + 4) % 4;
    case (k)
      0: begin ei = di;  eq = dq;  end
      1: begin ei = -dq; eq = di;  end
      2: begin ei = -di; eq = -dq; end
      default: begin ei = dq; eq = -di; end
    endcase
    s = acc_m + inc;
    if (s > 1608) s -= 3216;
    else if (s < -1608) s += 3216;
    acc_m = prst ? 0 : s;
    send(di, dq, 0, inc, prst, ei, eq);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() > 0; n++) idle(1);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_out_i", int'(out_i), 0);
    check("rst_out_q", int'(out_q), 0);
    check("rst_valid", int'(output_valid), 0);
    check("rst_addr", int'(rot_addr), 0);
    check("rst_perr", int'(phase_err), 0);
    check("rst_serr", int'(sat_err), 0);
    reset = 1'b0;

    send(1000, 0, 0, 0, 1'b0, 1000, 0);
    send(1000, 0, 804, 0, 1'b0, 0, 1000);
    send(1000, 0, -804, 0, 1'b0, 0, -1000);
    send(1000, 0, 1608, 0, 1'b0, -1000, 0);
    send(1000, 0, -1608, 0, 1'b0, -1000, 0);
    send(1000, 0, 2412, 0, 1'b0, 0, -1000);
    send(1000, 0, -2412, 0, 1'b0, 0, 1000);
    send(300, -700, 804, 0, 1'b0, 700, 300);
    send(-1234, 567, -804, 0, 1'b0, 567, 1234);
    drain();
    check("perr_wrap_clear", int'(phase_err), 0);
    check("serr_clear", int'(sat_err), 0);

    send(32767, 32767, 402, 0, 1'b0, 0, 32767);
    drain();
    check("serr_set", int'(sat_err), 1);

    send(0, 0, 4000, 0, 1'b0, 0, 0);
    drain();
    check("perr_set", int'(phase_err), 1);
    idle(5);
    check("perr_held", int'(phase_err), 1);

    mode = 1'b1;
    acc_m = 0;
    for (int n = 0; n < 5; n++) nco_send(1000, 0, 804, 1'b0);
    drain();
    acc_m = 0;
    nco_send(1000, 0, 804, 1'b1);
    nco_send(1000, 0, 804, 1'b0);
    nco_send(1000, 0, 804, 1'b1);
    nco_send(1000, 0, 804, 1'b0);
    nco_send(1000, 0, 804, 1'b0);
    drain();

    for (int n = 0; n < 100; n++) begin
      nco_send(int'($urandom_range(0, 40000)) - 20000,
               int'($urandom_range(0, 40000)) - 20000,
               inc_tab[$urandom_range(0, 3)],
               $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) stall(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    drain();

    nco_send(500, -250, 804, 1'b0);
    nco_send(500, -250, 804, 1'b0);
    nco_send(500, -250, 804, 1'b0);
    reset = 1'b1;
    sb.delete();
    acc_m = 0;
    @(negedge clk);
    check("mid_rst_out_i", int'(out_i), 0);
    check("mid_rst_out_q", int'(out_q), 0);
    check("mid_rst_valid", int'(output_valid), 0);
    check("mid_rst_addr", int'(rot_addr), 0);
    check("mid_rst_perr", int'(phase_err), 0);
    check("mid_rst_serr", int'(sat_err), 0);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) nco_send(1000, 0, 804, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
